// File: rtl/inv_cipher_seq.sv
// Iterative AES inverse cipher: one shared inverse round per clock, AES-128/192/256
// selected per request by the round count; illegal round counts return an error result.
module inv_cipher_seq #(
  parameter int MAX_NR = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [127:0]               i_data,
  input  logic [3:0]                 i_nr,
  input  logic [128*(MAX_NR+1)-1:0]  expanded_key,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [127:0]               o_data,
  output logic                       o_err,
  output logic [3:0]                 o_round,
  output logic [1:0]                 o_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // o_ready is high only in IDLE, o_valid only in DONE, and o_data/o_err hold until i_ready.
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  state_e        fsm_q;
  logic [127:0]  blk_q;
  logic [3:0]    nr_q;
  logic [3:0]    round_q;
  logic          valid_q;

  logic [127:0]  rk [0:MAX_NR];
  logic [3:0]    key_idx;
  logic [127:0]  key;
  logic [127:0]  final_d;
  logic [127:0]  round_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Byte 4*c+r of the block sits at bits [127-8*(4c+r) -: 8] (FIPS-197 column order).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic nr_legal(input logic [3:0] n);
    return (n == 4'd10) || (n == 4'd12) || (n == 4'd14);
  endfunction

  for (genvar k = 0; k <= MAX_NR; k++) begin : g_rk
    assign rk[k] = expanded_key[128*(MAX_NR-k) +: 128];
  end

  // In IDLE the key for the initial whitening comes straight from the request.
  assign key_idx = (fsm_q == S_IDLE) ? i_nr : round_q;

  always_comb begin
    key = '0;
    for (int k = 0; k <= MAX_NR; k++)
      if (key_idx == 4'(k)) key = rk[k];
  end

  assign final_d = inv_sub_bytes(inv_shift_rows(blk_q)) ^ key;
  assign round_d = inv_mix_columns(final_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      blk_q   <= '0;
      nr_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (i_valid) begin
            nr_q <= i_nr;
            if (nr_legal(i_nr)) begin
              blk_q   <= i_data ^ key;
              round_q <= i_nr - 4'd1;
              fsm_q   <= S_ROUND;
            end else begin
              blk_q   <= '0;
              round_q <= '0;
              valid_q <= 1'b1;
              fsm_q   <= S_DONE;
            end
          end
        end
        S_ROUND: begin
          blk_q   <= round_d;
          round_q <= round_q - 4'd1;
          if (round_q == 4'd1) fsm_q <= S_FINAL;
        end
        S_FINAL: begin
          blk_q   <= final_d;
          round_q <= '0;
          valid_q <= 1'b1;
          fsm_q   <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            fsm_q   <= S_IDLE;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign o_ready = (fsm_q == S_IDLE);
  assign o_valid = valid_q;
  assign o_data  = blk_q;
  assign o_err   = valid_q & ~nr_legal(nr_q);
  assign o_round = round_q;
  assign o_state = fsm_q;

endmodule

// File: tb/tb_inv_cipher_seq.sv
// Directed bench for inv_cipher_seq: FIPS-197 decryption vectors, backpressure,
// illegal round counts and mid-run reset.
module tb_inv_cipher_seq;

  logic           clk;
  logic           rst_n;
  logic           i_valid;
  logic           o_ready;
  logic [127:0]   i_data;
  logic [3:0]     i_nr;
  logic [1919:0]  expanded_key;
  logic           o_valid;
  logic           i_ready;
  logic [127:0]   o_data;
  logic           o_err;
  logic [3:0]     o_round;
  logic [1:0]     o_state;

  int checks;
  int errors;

  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_ALL = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [1919:0] ek128, ek192, ek256;

  inv_cipher_seq #(.MAX_NR(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_nr         (i_nr),
    .expanded_key (expanded_key),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_err        (o_err),
    .o_round      (o_round),
    .o_state      (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Forward-cipher helpers, used only to build the expanded key stimulus.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ek;
    int            nwords;
    nwords = 4 * (nk + 7);
    rc = 8'h01;
    ek = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nwords; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nwords; i++) ek[1919-32*i -: 32] = w[i];
    return ek;
  endfunction

  // Issues one request from a negedge, waits for the result, holds i_ready low for
  // `hold` cycles, then retires it. Returns at a negedge with the block in IDLE.
  task automatic run_req(input string tag, input logic [127:0] din, input logic [3:0] nr,
                         input logic [1919:0] ek, input logic [127:0] exp_d,
                         input logic exp_err, input int exp_lat, input int hold);
    int         lat;
    logic [3:0] exp_round;
    exp_round = nr - 4'd1;
    check({tag, "_ready_idle"}, 128'(o_ready), 128'd1);
    i_valid      = 1'b1;
    i_data       = din;
    i_nr         = nr;
    expanded_key = ek;
    i_ready      = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = '0;
    i_nr    = '0;
    if (!exp_err) check({tag, "_round_start"}, 128'(o_round), 128'(exp_round));
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_valid"}, 128'(o_valid), 128'd1);
    check({tag, "_data"}, o_data, exp_d);
    check({tag, "_err"}, 128'(o_err), 128'(exp_err));
    check({tag, "_round_done"}, 128'(o_round), 128'd0);
    check({tag, "_ready_done"}, 128'(o_ready), 128'd0);
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1;
      i_data  = ~din;
      i_nr    = 4'd10;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 128'(o_valid), 128'd1);
      check({tag, "_hold_data"}, o_data, exp_d);
      check({tag, "_hold_ready"}, 128'(o_ready), 128'd0);
    end
    i_valid = 1'b0;
    i_data  = '0;
    i_nr    = '0;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_retire_valid"}, 128'(o_valid), 128'd0);
    check({tag, "_retire_err"}, 128'(o_err), 128'd0);
    check({tag, "_retire_ready"}, 128'(o_ready), 128'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(o_valid), 128'd0);
    check({tag, "_ready"}, 128'(o_ready), 128'd1);
    check({tag, "_err"}, 128'(o_err), 128'd0);
    check({tag, "_round"}, 128'(o_round), 128'd0);
    check({tag, "_data"}, o_data, 128'd0);
    check({tag, "_state"}, 128'(o_state), 128'd0);
  endtask

  initial begin
    int n;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    i_valid      = 1'b0;
    i_data       = '0;
    i_nr         = '0;
    i_ready      = 1'b1;
    expanded_key = '0;
    ek128 = expand_key({KEY_ALL[255:128], 128'h0}, 4);
    ek192 = expand_key({KEY_ALL[255:64], 64'h0}, 6);
    ek256 = expand_key(KEY_ALL, 8);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_req("aes128", CT128, 4'd10, ek128, PT, 1'b0, 10, 0);
    run_req("aes192", CT192, 4'd12, ek192, PT, 1'b0, 12, 0);
    run_req("aes256", CT256, 4'd14, ek256, PT, 1'b0, 14, 0);

    run_req("bp128", CT128, 4'd10, ek128, PT, 1'b0, 10, 5);
    run_req("after_bp", CT192, 4'd12, ek192, PT, 1'b0, 12, 0);

    run_req("nr11", CT128, 4'd11, ek128, 128'd0, 1'b1, 0, 0);
    run_req("after_nr11", CT256, 4'd14, ek256, PT, 1'b0, 14, 0);
    run_req("nr15", CT256, 4'd15, ek256, 128'd0, 1'b1, 0, 2);
    run_req("nr0", CT128, 4'd0, ek128, 128'd0, 1'b1, 0, 0);

    i_valid      = 1'b1;
    i_data       = CT128;
    i_nr         = 4'd10;
    expanded_key = ek128;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (o_round != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrun_round5", 128'(o_round), 128'd5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrun_no_valid", 128'(o_valid), 128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_req("post_reset", CT128, 4'd10, ek128, PT, 1'b0, 10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
